// File: rtl/wb_multi_master_ctrl.sv
// Registered Wishbone master front-end: arbitrates N_MST requesters onto one bus,
// one transaction at a time, with a bus watchdog and per-master ack/err return.
module wb_multi_master_ctrl #(
  parameter int N_MST   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 64,
  localparam int SW     = DW / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MST-1:0]    m_req_i,
  input  logic [N_MST-1:0]    m_we_i,
  input  logic [N_MST*AW-1:0] m_adr_i,
  input  logic [N_MST*DW-1:0] m_dat_i,
  input  logic [N_MST*SW-1:0] m_sel_i,
  input  logic [N_MST-1:0]    m_mask_i,
  output logic [DW-1:0]       m_dat_o,
  output logic [N_MST-1:0]    m_ack_o,
  output logic [N_MST-1:0]    m_err_o,
  output logic [N_MST-1:0]    grant_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [AW-1:0]       wb_adr_o,
  output logic [DW-1:0]       wb_dat_o,
  output logic [SW-1:0]       wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DW-1:0]       wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  // state  | meaning
  // S_IDLE | no owner; arbitrate eligible requesters and launch a cycle
  // S_BUS  | cyc/stb asserted, waiting for ack, err or watchdog expiry
  // S_RESP | ack/err pulse visible to the owner; grant still held

  localparam int PW    = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [N_MST-1:0] r_grant;
  logic [N_MST-1:0] r_ack;
  logic [N_MST-1:0] r_err;
  logic             r_busy;
  logic             r_timeout;
  logic [DW-1:0]    r_rdat;
  logic [AW-1:0]    r_adr;
  logic [DW-1:0]    r_wdat;
  logic [SW-1:0]    r_sel;
  logic             r_we;
  logic             r_cyc;
  logic             r_stb;

  logic [N_MST-1:0] w_elig;
  logic [PW-1:0]    w_win;
  logic             w_found;
  int               w_idx;
  logic [AW-1:0]    w_adr_arr [N_MST];
  logic [DW-1:0]    w_dat_arr [N_MST];
  logic [SW-1:0]    w_sel_arr [N_MST];

  for (genvar k = 0; k < N_MST; k++) begin : g_unpack
    assign w_adr_arr[k] = m_adr_i[k*AW +: AW];
    assign w_dat_arr[k] = m_dat_i[k*DW +: DW];
    assign w_sel_arr[k] = m_sel_i[k*SW +: SW];
  end

  assign w_elig = m_req_i & ~m_mask_i;

  // Round-robin scans upward from the slot after the last winner; fixed priority scans from 0.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_MST; i++) begin
      if (RR_MODE != 0) begin
        w_idx = int'(r_ptr) + i + 1;
        if (w_idx >= N_MST) w_idx = w_idx - N_MST;
      end else begin
        w_idx = i;
      end
      if (!w_found && w_elig[PW'(w_idx)]) begin
        w_win   = PW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= PW'(N_MST - 1);
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_rdat    <= '0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_ack     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_adr   <= w_adr_arr[w_win];
            r_wdat  <= w_dat_arr[w_win];
            r_sel   <= w_sel_arr[w_win];
            r_we    <= m_we_i[w_win];
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_grant <= N_MST'(1) << w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            if (RR_MODE != 0) r_ptr <= w_win;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          // err outranks a simultaneous ack; the watchdog only fires on a silent cycle
          if (wb_err_i) begin
            r_err   <= r_grant;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= S_RESP;
          end else if (wb_ack_i) begin
            r_ack   <= r_grant;
            r_rdat  <= wb_dat_i;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= S_RESP;
          end else if (WD_EN && (r_cnt == CW'(TIMEOUT - 1))) begin
            r_err     <= r_grant;
            r_timeout <= 1'b1;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_dat_o   = r_rdat;
  assign m_ack_o   = r_ack;
  assign m_err_o   = r_err;
  assign grant_o   = r_grant;
  assign busy_o    = r_busy;
  assign timeout_o = r_timeout;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_wdat;
  assign wb_sel_o  = r_sel;
  assign wb_we_o   = r_we;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;

endmodule

// File: tb/tb_wb_multi_master_ctrl.sv
// Bench for wb_multi_master_ctrl: a round-robin and a fixed-priority instance share stimulus
// and are checked each cycle against a transaction-level model plus literal expectations.
module tb_wb_multi_master_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, mask;
  logic [63:0] adr, wdat;
  logic [7:0]  sel;
  logic [31:0] s_dat;
  logic        s_ack, s_err;

  logic [31:0] o_mdat [2];
  logic [1:0]  o_ack [2], o_err [2], o_grant [2];
  logic        o_busy [2], o_to [2], o_we [2], o_cyc [2], o_stb [2];
  logic [31:0] o_adr [2], o_wdat [2];
  logic [3:0]  o_sel [2];

  logic [31:0] e_mdat [2];
  logic [1:0]  e_ack [2], e_err [2], e_grant [2];
  logic        e_busy [2], e_to [2], e_we [2], e_cyc [2];
  logic [31:0] e_adr [2], e_wdat [2];
  logic [3:0]  e_sel [2];
  int          phase [2], lastg [2], nbus [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wb_multi_master_ctrl #(
      .N_MST(2), .AW(32), .DW(32), .RR_MODE((gi == 0) ? 1 : 0), .TIMEOUT(TO)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m_req_i(req), .m_we_i(we), .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
      .m_mask_i(mask),
      .m_dat_o(o_mdat[gi]), .m_ack_o(o_ack[gi]), .m_err_o(o_err[gi]),
      .grant_o(o_grant[gi]), .busy_o(o_busy[gi]), .timeout_o(o_to[gi]),
      .wb_adr_o(o_adr[gi]), .wb_dat_o(o_wdat[gi]), .wb_sel_o(o_sel[gi]),
      .wb_we_o(o_we[gi]), .wb_cyc_o(o_cyc[gi]), .wb_stb_o(o_stb[gi]),
      .wb_dat_i(s_dat), .wb_ack_i(s_ack), .wb_err_i(s_err)
    );
  end

  // Winner among eligible masters: rr searches after the previous winner, else lowest index.
  function automatic int pick(input logic [1:0] el, input int last, input bit rr);
    if (!rr) return el[0] ? 0 : 1;
    for (int k = 1; k <= 2; k++)
      if (el[(last + k) % 2]) return (last + k) % 2;
    return 0;
  endfunction

  // Transaction model: a grant opens a cycle; it ends on err, ack, or after TO silent cycles.
  always @(posedge clk or posedge rst) begin
    logic [1:0] el;
    int g;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        e_mdat[i] = '0; e_ack[i] = '0; e_err[i] = '0; e_grant[i] = '0;
        e_busy[i] = 0; e_to[i] = 0; e_we[i] = 0; e_cyc[i] = 0;
        e_adr[i] = '0; e_wdat[i] = '0; e_sel[i] = '0;
        phase[i] = 0; lastg[i] = 1; nbus[i] = 0;
      end else begin
        e_ack[i] = '0; e_err[i] = '0; e_to[i] = 0;
        if (phase[i] == 0) begin
          el = req & ~mask;
          if (el != 2'b00) begin
            g = pick(el, lastg[i], i == 0);
            lastg[i] = g;
            e_grant[i] = 2'(1 << g);
            e_adr[i] = adr[g*32 +: 32];
            e_wdat[i] = wdat[g*32 +: 32];
            e_sel[i] = sel[g*4 +: 4];
            e_we[i] = we[g];
            e_cyc[i] = 1; e_busy[i] = 1;
            nbus[i] = 1; phase[i] = 1;
          end
        end else if (phase[i] == 1) begin
          if (s_err || s_ack || nbus[i] == TO) begin
            if (s_err) e_err[i] = e_grant[i];
            else if (s_ack) begin e_ack[i] = e_grant[i]; e_mdat[i] = s_dat; end
            else begin e_err[i] = e_grant[i]; e_to[i] = 1; end
            e_cyc[i] = 0; phase[i] = 2;
          end else begin
            nbus[i] = nbus[i] + 1;
          end
        end else begin
          e_grant[i] = '0; e_busy[i] = 0; phase[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if ({o_grant[i], o_busy[i], o_ack[i], o_err[i], o_to[i], o_mdat[i], o_adr[i],
             o_wdat[i], o_sel[i], o_we[i], o_cyc[i], o_stb[i]} !==
            {e_grant[i], e_busy[i], e_ack[i], e_err[i], e_to[i], e_mdat[i], e_adr[i],
             e_wdat[i], e_sel[i], e_we[i], e_cyc[i], e_cyc[i]}) begin
          n_fail++;
          $display("FAIL cycle_cmp dut%0d t=%0t actual/required grant=%b/%b busy=%b/%b ack=%b/%b err=%b/%b to=%b/%b mdat=%h/%h adr=%h/%h wdat=%h/%h sel=%h/%h we=%b/%b cyc=%b/%b stb=%b/%b",
                   i, $time, o_grant[i], e_grant[i], o_busy[i], e_busy[i], o_ack[i], e_ack[i],
                   o_err[i], e_err[i], o_to[i], e_to[i], o_mdat[i], e_mdat[i], o_adr[i], e_adr[i],
                   o_wdat[i], e_wdat[i], o_sel[i], e_sel[i], o_we[i], e_we[i],
                   o_cyc[i], e_cyc[i], o_stb[i], e_cyc[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string nm, output int waited);
    int n = 0;
    while (!o_cyc[0] && n < 20) begin
      tick();
      n++;
    end
    if (!o_cyc[0]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s wait_cyc actual=cyc_low required=cyc_high within 20 cycles", nm);
    end
    waited = n;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] d);
    s_ack = 1'b1;
    s_dat = d;
    tick();
    s_ack = 1'b0;
  endtask

  logic [1:0] ga [4], gb [4];
  int w, nb;

  initial begin
    rst = 1'b1; req = '0; we = '0; mask = '0; adr = '0; wdat = '0; sel = 8'h3C;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_grant", 64'(o_grant[0]), 64'h0);
    chk("rst_cyc", 64'(o_cyc[0]), 64'h0);
    chk("rst_busy", 64'(o_busy[1]), 64'h0);
    tick();
    rst = 1'b0;

    // single read, slave acks in the second BUS cycle
    adr = {32'h1000_0010, 32'h2000_0004};
    wdat = {32'h1111_1111, 32'h0000_5555};
    req = 2'b01;
    tick();
    chk("rd_cyc_bus1", 64'(o_cyc[0]), 64'h1);
    chk("rd_adr", 64'(o_adr[0]), 64'h2000_0004);
    tick();
    chk("rd_cyc_bus2", 64'(o_cyc[0]), 64'h1);
    ack_now(32'hDEAD_BEEF);
    req = 2'b00;
    chk("rd_ack", 64'(o_ack[0]), 64'h1);
    chk("rd_dat", 64'(o_mdat[0]), 64'hDEAD_BEEF);
    chk("rd_cyc_resp", 64'(o_cyc[0]), 64'h0);
    tick();
    chk("rd_idle_grant", 64'(o_grant[0]), 64'h0);

    // both masters hold req: rr alternates, fixed priority keeps m0
    reset_pulse();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_cyc("rr", w);
      if (k > 0) chk("b2b_gap", 64'(w), 64'd2);
      ga[k] = o_grant[0];
      gb[k] = o_grant[1];
      ack_now(32'h100 + 32'(k));
    end
    chk("rr_order", 64'({ga[0], ga[1], ga[2], ga[3]}), 64'b01_10_01_10);
    chk("fixed_order", 64'({gb[0], gb[1], gb[2], gb[3]}), 64'b01_01_01_01);
    req = 2'b10;
    wait_cyc("m0_drop", w);
    chk("fixed_m0_drop", 64'(o_grant[1]), 64'h2);
    ack_now(32'h0000_0ABC);
    req = 2'b00;
    tick();

    // mask excludes m0; masking mid-BUS does not abort
    mask = 2'b01;
    req = 2'b11;
    wait_cyc("mask", w);
    chk("mask_grant_rr", 64'(o_grant[0]), 64'h2);
    chk("mask_grant_fix", 64'(o_grant[1]), 64'h2);
    ack_now(32'h2222_0000);
    req = 2'b00; mask = 2'b00;
    tick();
    adr[31:0] = 32'h3000_0000;
    req = 2'b01;
    wait_cyc("mask_mid", w);
    chk("mask_mid_grant", 64'(o_grant[0]), 64'h1);
    mask = 2'b01;
    tick();
    ack_now(32'h1234_5678);
    chk("mask_mid_ack", 64'(o_ack[0]), 64'h1);
    chk("mask_mid_dat", 64'(o_mdat[0]), 64'h1234_5678);
    req = 2'b00; mask = 2'b00;
    tick();

    // watchdog on a write that is never acknowledged, then a late ack
    we = 2'b01;
    wdat[31:0] = 32'hCAFE_0001;
    req = 2'b01;
    wait_cyc("to", w);
    nb = 0;
    while (o_cyc[0] && nb < 20) begin
      nb++;
      tick();
    end
    chk("to_bus_cycles", 64'(nb), 64'd8);
    chk("to_err", 64'(o_err[0]), 64'h1);
    chk("to_flag", 64'(o_to[0]), 64'h1);
    chk("to_no_ack", 64'(o_ack[0]), 64'h0);
    req = 2'b00; we = 2'b00;
    tick();
    ack_now(32'hBAD0_BAD0);
    chk("late_ack", 64'(o_ack[0]), 64'h0);
    chk("late_err", 64'(o_err[0]), 64'h0);
    tick();

    // ack and err together: only err reaches the owner
    req = 2'b10;
    wait_cyc("ackerr", w);
    s_err = 1'b1;
    ack_now(32'h7777_7777);
    s_err = 1'b0;
    chk("ae_err", 64'(o_err[0]), 64'h2);
    chk("ae_ack", 64'(o_ack[0]), 64'h0);
    req = 2'b00;
    tick();

    // reset mid-BUS with an ack pending
    req = 2'b01;
    wait_cyc("rst_mid", w);
    tick();
    s_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc", 64'(o_cyc[0]), 64'h0);
    chk("rst_mid_grant", 64'(o_grant[0]), 64'h0);
    chk("rst_mid_busy", 64'(o_busy[0]), 64'h0);
    tick();
    rst = 1'b0; s_ack = 1'b0; req = 2'b00;
    chk("rst_mid_noack", 64'(o_ack[0]), 64'h0);
    tick();
    chk("rst_mid_noack2", 64'({o_ack[0], o_err[0]}), 64'h0);
    req = 2'b10;
    wait_cyc("post_rst_m1", w);
    chk("post_rst_m1", 64'(o_grant[0]), 64'h2);
    ack_now(32'h0000_0001);
    req = 2'b00;
    tick();
    req = 2'b11;
    wait_cyc("post_rst_both", w);
    chk("post_rst_m0", 64'(o_grant[0]), 64'h1);
    ack_now(32'h0000_0002);
    req = 2'b00;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
